// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : Decodes alu_op/funct3/funct7 into a 4-bit operation and executes
//             it on XLEN-bit operands behind a valid/ready handshake. Optional
//             iterative unsigned MUL/MULHU/DIVU/REMU when ALU_MULDIV_EN is set.
//  Revision : 1.0  initial release
// ============================================================================
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  localparam int c_SHW = $clog2(XLEN);

  localparam logic [3:0] c_OP_ADD   = 4'b0000;
  localparam logic [3:0] c_OP_SUB   = 4'b0001;
  localparam logic [3:0] c_OP_AND   = 4'b0010;
  localparam logic [3:0] c_OP_OR    = 4'b0011;
  localparam logic [3:0] c_OP_SLL   = 4'b0100;
  localparam logic [3:0] c_OP_SLT   = 4'b0101;
  localparam logic [3:0] c_OP_XOR   = 4'b0110;
  localparam logic [3:0] c_OP_SRL   = 4'b0111;
  localparam logic [3:0] c_OP_SRA   = 4'b1000;
  localparam logic [3:0] c_OP_SLTU  = 4'b1001;
  localparam logic [3:0] c_OP_MUL   = 4'b1010;
  localparam logic [3:0] c_OP_MULHU = 4'b1011;
  localparam logic [3:0] c_OP_DIVU  = 4'b1100;
  localparam logic [3:0] c_OP_REMU  = 4'b1101;

  logic [3:0]       w_op;
  logic             w_illegal;
  logic [XLEN-1:0]  w_imm;
  logic [c_SHW-1:0] w_shamt;
  logic             w_fire;
  logic             w_idle;
  logic             w_start_iter;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_result;
  logic             r_zero;
  logic             r_illegal;

  // ---------------------------------------------------------------- decode
  always_comb begin
    w_op      = c_OP_ADD;
    w_illegal = 1'b0;
    if (alu_op == 2'b00) begin
      w_op = c_OP_ADD;
    end else if (alu_op == 2'b01) begin
      w_op = c_OP_SUB;
    end else if (alu_op == 2'b10 && funct7b0) begin
`ifdef ALU_MULDIV_EN
      case (funct3)
        3'b000:  w_op = c_OP_MUL;
        3'b011:  w_op = c_OP_MULHU;
        3'b101:  w_op = c_OP_DIVU;
        3'b111:  w_op = c_OP_REMU;
        default: w_illegal = 1'b1;
      endcase
`else
      w_illegal = 1'b1;
`endif
    end else begin
      case (funct3)
        3'b000:  w_op = (alu_op == 2'b10 && funct7b5) ? c_OP_SUB : c_OP_ADD;
        3'b001:  w_op = c_OP_SLL;
        3'b010:  w_op = c_OP_SLT;
        3'b011:  w_op = c_OP_SLTU;
        3'b100:  w_op = c_OP_XOR;
        3'b101:  w_op = funct7b5 ? c_OP_SRA : c_OP_SRL;
        3'b110:  w_op = c_OP_OR;
        default: w_op = c_OP_AND;
      endcase
    end
  end

  // ------------------------------------------------- single-cycle datapath
  assign w_shamt = src_b[c_SHW-1:0];

  // DIVU/REMU only reach this path with a zero divisor.
  always_comb begin
    w_imm = '0;
    case (w_op)
      c_OP_ADD:   w_imm = src_a + src_b;
      c_OP_SUB:   w_imm = src_a - src_b;
      c_OP_AND:   w_imm = src_a & src_b;
      c_OP_OR:    w_imm = src_a | src_b;
      c_OP_XOR:   w_imm = src_a ^ src_b;
      c_OP_SLL:   w_imm = src_a << w_shamt;
      c_OP_SRL:   w_imm = src_a >> w_shamt;
      c_OP_SRA:   w_imm = $unsigned($signed(src_a) >>> w_shamt);
      c_OP_SLT:   w_imm = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      c_OP_SLTU:  w_imm = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      c_OP_DIVU:  w_imm = '1;
      c_OP_REMU:  w_imm = src_a;
      c_OP_MUL,
      c_OP_MULHU: w_imm = '0;
      default:    w_imm = '0;
    endcase
    if (w_illegal) begin
      w_imm = '0;
    end
  end

  assign w_fire   = in_valid && in_ready;
  assign in_ready = w_idle && (!r_out_valid || out_ready);

`ifdef ALU_MULDIV_EN
  // -------------------------------------------------- iterative datapath
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opnd;
  logic [c_SHW-1:0]    r_cnt;
  logic                r_hi_sel;

  logic                w_start_mul;
  logic                w_start_div;
  logic                w_last;
  logic [XLEN:0]       w_mul_sum;
  logic [XLEN:0]       w_div_shift;
  logic [XLEN:0]       w_div_diff;
  logic [2*XLEN-1:0]   w_mul_next;
  logic [2*XLEN-1:0]   w_div_next;
  logic [2*XLEN-1:0]   w_acc_next;
  logic [XLEN-1:0]     w_iter_result;

  assign w_start_mul  = (w_op == c_OP_MUL) || (w_op == c_OP_MULHU);
  assign w_start_div  = ((w_op == c_OP_DIVU) || (w_op == c_OP_REMU)) && (src_b != '0);
  assign w_start_iter = w_start_mul || w_start_div;
  assign w_idle       = (r_state == S_IDLE);
  assign w_last       = (r_cnt == c_SHW'(XLEN - 1));

  // Multiply: acc = {partial, multiplier}; add multiplicand into the top half
  // when the current multiplier bit is set, then shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]}
                    + (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: acc = {remainder, quotient/dividend}; shift left, trial-subtract.
  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_next  = w_div_diff[XLEN]
                     ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                     : {w_div_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

  assign w_acc_next    = (r_state == S_MUL) ? w_mul_next : w_div_next;
  assign w_iter_result = r_hi_sel ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
  assign busy          = r_busy;
`else
  assign w_start_iter = 1'b0;
  assign w_idle       = 1'b1;
  assign busy         = 1'b0;
`endif

  // ------------------------------------------------------ control + output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
`ifdef ALU_MULDIV_EN
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_cnt       <= '0;
      r_hi_sel    <= 1'b0;
`endif
    end else begin
      if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_fire && !w_start_iter) begin
        r_out_valid <= 1'b1;
        r_result    <= w_imm;
        r_zero      <= (w_imm == '0);
        r_illegal   <= w_illegal;
      end
`ifdef ALU_MULDIV_EN
      case (r_state)
        S_IDLE: begin
          if (w_fire && w_start_mul) begin
            r_state  <= S_MUL;
            r_busy   <= 1'b1;
            r_acc    <= {{XLEN{1'b0}}, src_b};
            r_opnd   <= src_a;
            r_cnt    <= '0;
            r_hi_sel <= (w_op == c_OP_MULHU);
          end else if (w_fire && w_start_div) begin
            r_state  <= S_DIV;
            r_busy   <= 1'b1;
            r_acc    <= {{XLEN{1'b0}}, src_a};
            r_opnd   <= src_b;
            r_cnt    <= '0;
            r_hi_sel <= (w_op == c_OP_REMU);
          end
        end
        S_MUL, S_DIV: begin
          // The output register is empty here: acceptance required it drained.
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_result    <= w_iter_result;
            r_zero      <= (w_iter_result == '0);
            r_illegal   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
`endif
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Purpose  : Self-checking bench for alu_exec_unit: directed cases plus
//             randomized transactions against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_unit;

  localparam int XLEN = 32;
  localparam int SHW  = 5;
`ifdef ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            funct7b0;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .funct7b0  (funct7b0),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: instruction semantics computed directly.
  function automatic void ref_op(input logic [1:0] op, input logic [2:0] f3,
                                 input logic f5, input logic f0,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 output logic [XLEN-1:0] res, output logic ill,
                                 output int lat);
    logic [2*XLEN-1:0] p;
    logic [SHW-1:0]    sh;
    p   = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    sh  = b[SHW-1:0];
    res = '0;
    ill = 1'b0;
    lat = 0;
    if (op == 2'b10 && f0) begin
      if (!MULDIV) begin
        ill = 1'b1;
      end else begin
        case (f3)
          3'b000: begin res = p[XLEN-1:0];      lat = XLEN; end
          3'b011: begin res = p[2*XLEN-1:XLEN]; lat = XLEN; end
          3'b101: if (b == '0) res = '1; else begin res = a / b; lat = XLEN; end
          3'b111: if (b == '0) res = a;  else begin res = a % b; lat = XLEN; end
          default: ill = 1'b1;
        endcase
      end
    end else if (op == 2'b00) begin
      res = a + b;
    end else if (op == 2'b01) begin
      res = a - b;
    end else begin
      case (f3)
        3'b000: if (op == 2'b10 && f5) res = a - b; else res = a + b;
        3'b001: res = a << sh;
        3'b010: res = ($signed(a) < $signed(b)) ? 1 : 0;
        3'b011: res = (a < b) ? 1 : 0;
        3'b100: res = a ^ b;
        3'b101: if (f5) res = $unsigned($signed(a) >>> sh); else res = a >> sh;
        3'b110: res = a | b;
        default: res = a & b;
      endcase
    end
  endfunction

  function automatic logic [XLEN-1:0] pick();
    logic [XLEN-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = 1;
      2: v = '1;
      3: v = 32'h8000_0000;
      4: v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // One transaction: issue, wait for result, check, optionally stall, drain.
  task automatic run_txn(input logic [1:0] op, input logic [2:0] f3, input logic f5,
                         input logic f0, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input int hold, input string tag);
    logic [XLEN-1:0] er;
    logic            ei;
    int              elat;
    int              n;
    ref_op(op, f3, f5, f0, a, b, er, ei, elat);
    out_ready = (hold == 0);
    alu_op    = op;
    funct3    = f3;
    funct7b5  = f5;
    funct7b0  = f0;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 2*XLEN + 8) begin
      tick();
      n++;
    end
    check({tag, "/in_ready"}, 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    src_a    = $urandom;
    src_b    = $urandom;
    alu_op   = 2'($urandom);
    funct3   = 3'($urandom);
    n = 0;
    while (!out_valid && n < XLEN + 8) begin
      tick();
      n++;
    end
    check({tag, "/latency"}, 64'(n), 64'(elat));
    check({tag, "/result"}, 64'(result), 64'(er));
    check({tag, "/zero"}, 64'(zero), 64'(er == '0));
    check({tag, "/illegal"}, 64'(illegal), 64'(ei));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "/hold_valid"}, 64'(out_valid), 64'(1));
      check({tag, "/hold_result"}, 64'(result), 64'(er));
      check({tag, "/hold_in_ready"}, 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    check({tag, "/drain"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = 2'b00;
    funct3    = 3'b000;
    funct7b5  = 1'b0;
    funct7b0  = 1'b0;
    src_a     = '0;
    src_b     = '0;
    repeat (3) tick();
    check("reset/out_valid", 64'(out_valid), 64'(0));
    check("reset/result", 64'(result), 64'(0));
    check("reset/zero", 64'(zero), 64'(0));
    check("reset/illegal", 64'(illegal), 64'(0));
    check("reset/busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    tick();
    check("reset/in_ready", 64'(in_ready), 64'(1));

    // Directed cases
    run_txn(2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 0, "sub_r");
    run_txn(2'b11, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 0, "addi_f5");
    run_txn(2'b11, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 0, "srai");
    run_txn(2'b11, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 0, "srli");
    run_txn(2'b10, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, "slt");
    run_txn(2'b10, 3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, "sltu");
    run_txn(2'b01, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 0, "branch_eq");
    run_txn(2'b10, 3'b001, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0021, 0, "sll_wrap");
    run_txn(2'b10, 3'b000, 1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, 0, "mul");
    run_txn(2'b10, 3'b011, 1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, 0, "mulhu");
    run_txn(2'b10, 3'b101, 1'b0, 1'b1, 32'd100, 32'd7, 0, "divu");
    run_txn(2'b10, 3'b111, 1'b0, 1'b1, 32'd100, 32'd7, 0, "remu");
    run_txn(2'b10, 3'b101, 1'b0, 1'b1, 32'd100, 32'd0, 0, "divu_zero");
    run_txn(2'b10, 3'b111, 1'b0, 1'b1, 32'd100, 32'd0, 0, "remu_zero");
    run_txn(2'b10, 3'b010, 1'b0, 1'b1, 32'd3, 32'd4, 0, "m_illegal");
    run_txn(2'b00, 3'b000, 1'b0, 1'b0, 32'd3, 32'd4, 3, "ld_hold");

    // Backpressure with a new request accepted on the release cycle
    out_ready = 1'b0;
    alu_op = 2'b00; funct3 = 3'b000; funct7b5 = 1'b0; funct7b0 = 1'b0;
    src_a = 32'd3; src_b = 32'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp/valid", 64'(out_valid), 64'(1));
    check("bp/result", 64'(result), 64'(7));
    for (int i = 0; i < 5; i++) begin
      src_a = $urandom;
      tick();
      check("bp/held", 64'(result), 64'(7));
      check("bp/in_ready", 64'(in_ready), 64'(0));
    end
    alu_op = 2'b10; funct3 = 3'b100; src_a = 32'hF0; src_b = 32'hFF;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("bp/release_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    check("bp/next_valid", 64'(out_valid), 64'(1));
    check("bp/next_result", 64'(result), 64'(32'h0F));
    tick();
    check("bp/drained", 64'(out_valid), 64'(0));

    // Reset while a result is pending / while iterating
    out_ready = 1'b0;
    alu_op = 2'b00; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("rst_pending/valid", 64'(out_valid), 64'(0));
    check("rst_pending/result", 64'(result), 64'(0));
`ifdef ALU_MULDIV_EN
    alu_op = 2'b10; funct3 = 3'b000; funct7b5 = 1'b0; funct7b0 = 1'b1;
    src_a = 32'd12345; src_b = 32'd678; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("rst_mul/busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mul/valid", 64'(out_valid), 64'(0));
    check("rst_mul/busy", 64'(busy), 64'(0));
    repeat (XLEN + 4) tick();
    check("rst_mul/no_late_result", 64'(out_valid), 64'(0));
`endif
    run_txn(2'b00, 3'b000, 1'b0, 1'b0, 32'd40, 32'd2, 0, "add_after_rst");

    // Randomized transactions
    for (int k = 0; k < 150; k++) begin
      logic [1:0]      r_op;
      logic [2:0]      r_f3;
      logic            r_f5;
      logic            r_f0;
      logic [XLEN-1:0] r_a;
      logic [XLEN-1:0] r_b;
      int              r_hold;
      r_op   = 2'($urandom);
      r_f3   = 3'($urandom);
      r_f5   = 1'($urandom);
      r_f0   = 1'($urandom);
      r_a    = pick();
      r_b    = pick();
      r_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_txn(r_op, r_f3, r_f5, r_f0, r_a, r_b, r_hold, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
